// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch path between the queue and the pre-decoder.
package prefetch_queue_pkg;

  localparam int PREFETCH_BYTES = 8;

  // Head-of-queue window as seen by the pre-decoder; bytes[0] is the oldest byte.
  typedef struct packed {
    logic [PREFETCH_BYTES-1:0][7:0] bytes;
    logic [3:0]                     count;
    logic [15:0]                    pc;
  } prefetch_window_t;

  // Bytes a fetch at this offset delivers: the high byte only when odd, the whole word when even.
  function automatic logic [1:0] fetch_need(input logic odd);
    return odd ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// Bus-unit and pre-decoder handshake bundle for the prefetch queue.
interface prefetch_queue_if #(
  parameter int QUEUE_BYTES = 8,
  parameter int CNT_W       = 4
);
  import prefetch_queue_pkg::*;

  logic                     flush;
  logic [15:0]              flush_pc;
  logic                     fetch_req;
  logic [15:0]              fetch_addr;
  logic                     fetch_start;
  logic                     fetch_ack;
  logic [15:0]              fetch_data;
  logic [8*QUEUE_BYTES-1:0] q_bytes;
  logic [CNT_W-1:0]         q_count;
  logic [15:0]              q_pc;
  logic [CNT_W-1:0]         consume;

  modport master (
    output flush, flush_pc, fetch_start, fetch_ack, fetch_data, consume,
    input  fetch_req, fetch_addr, q_bytes, q_count, q_pc
  );

  modport slave (
    input  flush, flush_pc, fetch_start, fetch_ack, fetch_data, consume,
    output fetch_req, fetch_addr, q_bytes, q_count, q_pc
  );

endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code words at the fetch offset, buffers them
// as bytes and presents the oldest bytes to the pre-decoder.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int QUEUE_BYTES = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  prefetch_queue_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QUEUE_BYTES);

  logic [8*QUEUE_BYTES-1:0] queue;
  logic [CNT_W-1:0]         count;
  logic [15:0]              pc;
  logic [15:0]              addr;
  logic                     outstanding;
  logic                     discard;

  logic [CNT_W-1:0]         eff;
  logic [CNT_W-1:0]         base;
  logic [CNT_W-1:0]         n_app;
  logic [CNT_W-1:0]         free;
  logic [CNT_W-1:0]         need;
  logic                     take;
  logic [8*QUEUE_BYTES-1:0] app;
  logic [8*QUEUE_BYTES-1:0] queue_nx;

  // Request decision uses registered occupancy only; same-cycle consume is not counted as free.
  always_comb begin
    free = DEPTH - count;
    need = CNT_W'(fetch_need(addr[0]));
    bus.fetch_req = !reset && !outstanding && !bus.flush && (free >= need);
  end

  // Byte-lane mux: shift out consumed bytes, then lay the fetched bytes at the new tail.
  always_comb begin
    eff   = (bus.consume > count) ? count : bus.consume;
    base  = count - eff;
    take  = bus.fetch_ack && !discard;
    n_app = '0;
    app   = '0;
    if (take) begin
      n_app     = CNT_W'(fetch_need(addr[0]));
      app[15:0] = addr[0] ? {8'h00, bus.fetch_data[15:8]} : bus.fetch_data;
    end
    // Lanes at and above the tail are zero, so the append can simply be OR-ed in.
    queue_nx = (queue >> {eff, 3'b000}) | (app << {base, 3'b000});
  end

  // Queue contents, fetch offset and bus-cycle tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      queue       <= '0;
      count       <= '0;
      pc          <= '0;
      addr        <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (ce) begin
      if (bus.fetch_ack)
        outstanding <= 1'b0;
      else if (bus.fetch_start)
        outstanding <= 1'b1;

      if (bus.flush) begin
        queue <= '0;
        count <= '0;
        pc    <= bus.flush_pc;
        addr  <= bus.flush_pc;
        // An ack in the flush cycle closes the stale bus cycle itself, so nothing is left to drop.
        discard <= (discard || outstanding || bus.fetch_start) && !bus.fetch_ack;
      end else begin
        queue <= queue_nx;
        count <= base + n_app;
        pc    <= pc + 16'(eff);
        if (take)
          addr <= addr + 16'(n_app);
        if (bus.fetch_ack)
          discard <= 1'b0;
      end
    end
  end

  assign bus.q_bytes    = queue;
  assign bus.q_count    = count;
  assign bus.q_pc       = pc;
  assign bus.fetch_addr = addr;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed scoreboard bench for prefetch_queue.
module tb_prefetch_queue;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  prefetch_queue_if #(.QUEUE_BYTES(8), .CNT_W(4)) bus();

  prefetch_queue #(.QUEUE_BYTES(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [3:0]  count;
    logic [63:0] bytes;
    logic [15:0] pc;
    logic [15:0] addr;
    logic        req;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare the DUT state against the oldest expectation on the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (bus.q_count !== e.count || bus.q_bytes !== e.bytes || bus.q_pc !== e.pc ||
          bus.fetch_addr !== e.addr || bus.fetch_req !== e.req) begin
        errors++;
        $display("FAIL %s: count=%0d exp %0d bytes=%h exp %h pc=%h exp %h addr=%h exp %h req=%b exp %b",
                 e.name, bus.q_count, e.count, bus.q_bytes, e.bytes, bus.q_pc, e.pc,
                 bus.fetch_addr, e.addr, bus.fetch_req, e.req);
      end
    end
  end

  // Protocol monitor: the pre-decoder must never retire more bytes than are valid.
  always @(posedge clk) begin
    if (!reset && ce && !bus.flush && bus.consume != 4'd0) begin
      checks++;
      if (bus.consume > bus.q_count) begin
        errors++;
        $display("FAIL consume_range: consume=%0d exceeds q_count=%0d", bus.consume, bus.q_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.flush       = 1'b0;
    bus.fetch_start = 1'b0;
    bus.fetch_ack   = 1'b0;
    bus.consume     = 4'd0;
  endtask

  task automatic expect_st(input string n, input logic [3:0] c, input logic [63:0] b,
                           input logic [15:0] p, input logic [15:0] a, input logic r);
    exp_t e;
    e.name = n; e.count = c; e.bytes = b; e.pc = p; e.addr = a; e.req = r;
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [15:0] d);
    bus.fetch_start = 1'b1;
    bus.fetch_ack   = 1'b1;
    bus.fetch_data  = d;
    tick();
  endtask

  task automatic do_flush(input logic [15:0] p);
    bus.flush    = 1'b1;
    bus.flush_pc = p;
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    ce              = 1'b1;
    bus.flush       = 1'b0;
    bus.flush_pc    = 16'h0000;
    bus.fetch_start = 1'b0;
    bus.fetch_ack   = 1'b0;
    bus.fetch_data  = 16'h0000;
    bus.consume     = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 4'd0, 64'h0, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
    expect_st("post_reset", 4'd0, 64'h0, 16'h0000, 16'h0000, 1'b1);

    // 1: zero-wait fetch at address 0
    do_ack(16'hB0C3);
    expect_st("t1_first", 4'd2, 64'hB0C3, 16'h0000, 16'h0002, 1'b1);

    // 2: odd flush target keeps only the high byte
    do_flush(16'h0101);
    expect_st("t2_flush", 4'd0, 64'h0, 16'h0101, 16'h0101, 1'b1);
    do_ack(16'h1234);
    expect_st("t2_odd", 4'd1, 64'h12, 16'h0101, 16'h0102, 1'b1);
    do_ack(16'h5678);
    expect_st("t2_even", 4'd3, 64'h567812, 16'h0101, 16'h0104, 1'b1);

    // 3: fill to full, outstanding blocks requests, drain back to two free
    do_flush(16'h0200);
    do_ack(16'h0201);
    do_ack(16'h0403);
    expect_st("t3_four", 4'd4, 64'h04030201, 16'h0200, 16'h0204, 1'b1);
    bus.fetch_start = 1'b1;
    tick();
    expect_st("t3_outstanding", 4'd4, 64'h04030201, 16'h0200, 16'h0204, 1'b0);
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = 16'h0605;
    tick();
    expect_st("t3_six", 4'd6, 64'h060504030201, 16'h0200, 16'h0206, 1'b1);
    do_ack(16'h0807);
    expect_st("t3_full", 4'd8, 64'h0807060504030201, 16'h0200, 16'h0208, 1'b0);
    bus.consume = 4'd1;
    tick();
    expect_st("t3_free1", 4'd7, 64'h0008070605040302, 16'h0201, 16'h0208, 1'b0);
    bus.consume = 4'd1;
    tick();
    expect_st("t3_free2", 4'd6, 64'h0000080706050403, 16'h0202, 16'h0208, 1'b1);

    // 4: consume and append in the same cycle
    do_flush(16'h0300);
    do_ack(16'hA1A0);
    do_ack(16'hA3A2);
    expect_st("t4_four", 4'd4, 64'hA3A2A1A0, 16'h0300, 16'h0304, 1'b1);
    bus.consume     = 4'd3;
    bus.fetch_start = 1'b1;
    bus.fetch_ack   = 1'b1;
    bus.fetch_data  = 16'hB1B0;
    tick();
    expect_st("t4_merge", 4'd3, 64'hB1B0A3, 16'h0303, 16'h0306, 1'b1);

    // 5: flush with a bus cycle in flight drops its data
    do_flush(16'h1000);
    bus.fetch_start = 1'b1;
    tick();
    expect_st("t5_pending", 4'd0, 64'h0, 16'h1000, 16'h1000, 1'b0);
    do_flush(16'h2000);
    expect_st("t5_flush", 4'd0, 64'h0, 16'h2000, 16'h2000, 1'b0);
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = 16'hFFFF;
    tick();
    expect_st("t5_drop", 4'd0, 64'h0, 16'h2000, 16'h2000, 1'b1);
    do_ack(16'h2211);
    expect_st("t5_next", 4'd2, 64'h2211, 16'h2000, 16'h2002, 1'b1);

    // 5b: start in the flush cycle, second flush, exactly one ack dropped
    bus.flush       = 1'b1;
    bus.flush_pc    = 16'h2400;
    bus.fetch_start = 1'b1;
    tick();
    expect_st("t5b_flush_start", 4'd0, 64'h0, 16'h2400, 16'h2400, 1'b0);
    do_flush(16'h2500);
    expect_st("t5b_reflush", 4'd0, 64'h0, 16'h2500, 16'h2500, 1'b0);
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = 16'hEEEE;
    tick();
    expect_st("t5b_drop", 4'd0, 64'h0, 16'h2500, 16'h2500, 1'b1);
    do_ack(16'h4433);
    expect_st("t5b_keep", 4'd2, 64'h4433, 16'h2500, 16'h2502, 1'b1);

    // 6: offset wrap at 0xFFFF
    do_flush(16'hFFFE);
    do_ack(16'h0201);
    expect_st("t6_wrap", 4'd2, 64'h0201, 16'hFFFE, 16'h0000, 1'b1);
    do_ack(16'h0403);
    expect_st("t6_next", 4'd4, 64'h04030201, 16'hFFFE, 16'h0002, 1'b1);
    bus.consume = 4'd3;
    tick();
    expect_st("t6_pc_wrap", 4'd1, 64'h04, 16'h0001, 16'h0002, 1'b1);

    // clock enable low freezes everything
    ce              = 1'b0;
    bus.fetch_start = 1'b1;
    bus.fetch_ack   = 1'b1;
    bus.fetch_data  = 16'h0605;
    bus.consume     = 4'd1;
    tick();
    expect_st("ce_hold", 4'd1, 64'h04, 16'h0001, 16'h0002, 1'b1);
    ce = 1'b1;
    bus.consume = 4'd1;
    tick();
    expect_st("drain", 4'd0, 64'h0, 16'h0002, 16'h0002, 1'b1);

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
